vec_serializer: RTL and testbench
=================================

// Module: vec_serializer
// PURPOSE
//   Upstream transmitter for the popcount pipeline. Accepts one full fingerprint vector
//   (VECTOR_WIDTH bits) per handshake and emits it as SUB_VECTOR_NO consecutive BUS_WIDTH
//   sub-vector words, LSB word first, over a valid/ready stream. Its output side drives the
//   up_Vector/up_Valid/up_Ready input of the cnt1 bit-count stage.
// PARAMETERS
//   VECTOR_WIDTH     920   bits per full vector
//   BUS_WIDTH        128   bits per sub-vector word on the output stream
//   SUB_VECTOR_NO    ceil(VECTOR_WIDTH/BUS_WIDTH) = 8   words per vector (derived, do not override)
//   WORD_CNTR_WIDTH  max(1,$clog2(SUB_VECTOR_NO))       word index width (derived)
// PORTS
//   clk           in   1                 single clock, all logic on rising edge
//   rst           in   1                 synchronous, active-high reset
//   up_Vector     in   VECTOR_WIDTH      full input vector
//   up_Valid      in   1                 up_Vector is valid
//   up_Ready      out  1                 block can accept a vector this cycle
//   dn_SubVector  out  BUS_WIDTH         current sub-vector word
//   dn_Valid      out  1                 dn_SubVector valid
//   dn_First      out  1                 current word is word 0 of a vector
//   dn_Last       out  1                 current word is word SUB_VECTOR_NO-1 of a vector
//   dn_Ready      in   1                 downstream accepts the word this cycle
// BEHAVIOUR
//   - Reset: dn_Valid=0, dn_First=0, dn_Last=0, dn_SubVector=0, word index=0, state IDLE;
//     up_Ready=1 from the first cycle after reset. Reset mid-vector discards remaining words.
//   - Storage: one holding register, SUB_VECTOR_NO*BUS_WIDTH bits; bits at and above
//     VECTOR_WIDTH are zero (pad). 920/128: words 0..6 full, word 7 = bits 919:896 + 104 zeros.
//   - Word k = hold[k*BUS_WIDTH +: BUS_WIDTH]; selection by registered index (mux or shift,
//     implementer's choice; output must be identical).
//   - States: IDLE (holding empty) and SEND (holding full, index = current word).
//     IDLE: up_Ready=1; up_Valid -> load, index=0, go SEND.
//     SEND: dn_Valid=1. On dn_Valid&&dn_Ready: if index<SUB_VECTOR_NO-1 then index+1;
//     else (last word) if up_Valid load next vector, index=0, stay SEND; otherwise go IDLE.
//   - up_Ready = IDLE || (SEND && dn_Last && dn_Ready). Combinational path dn_Ready->up_Ready
//     is permitted and required for zero-bubble back-to-back vectors.
//   - Latency: vector accepted at edge N -> word 0 on dn_SubVector during cycle N+1.
//     With dn_Ready held 1, a vector occupies exactly SUB_VECTOR_NO cycles; consecutive
//     vectors stream with no idle cycle between them.
//   - Stream stability: while dn_Valid=1 and dn_Ready=0, dn_SubVector/dn_First/dn_Last hold.
//     dn_Valid never deasserts without a completed handshake (except by reset).
//   - dn_First = SEND && index==0; dn_Last = SEND && index==SUB_VECTOR_NO-1; both high
//     together when SUB_VECTOR_NO==1. dn_SubVector outside SEND: don't-care, driven 0.
//   - up_Vector sampled only on an up_Valid&&up_Ready edge; changes at other times ignored.
//   - Index never exceeds SUB_VECTOR_NO-1; no wrap past last word.
// TESTING
//   1 Reset: assert rst 3 cycles with up_Valid=1 -> dn_Valid=0, up_Ready=1, no load occurs.
//   2 Single vector, dn_Ready=1, bit i = i%2 -> 8 words in cycles N+1..N+8, words 0..6 =
//     128'hAAAA..AA, word 7 = {104'h0, 24'hAAAAAA}; dn_First on word 0, dn_Last on word 7 only.
//   3 Backpressure: dn_Ready toggling 1,0,0,1,... -> every word appears exactly once, in order,
//     held stable during stalls; up_Ready=0 until last word handshake.
//   4 Back-to-back: two vectors, up_Valid and dn_Ready held 1 -> 16 words in 16 consecutive
//     cycles, second vector loaded on the edge of first vector's word 7 handshake.
//   5 Reset mid-vector after word 3 -> next cycle dn_Valid=0, IDLE; a new vector then starts
//     at word 0 with dn_First=1.
//   6 VECTOR_WIDTH=100, BUS_WIDTH=128 -> one word per vector, dn_First=dn_Last=1,
//     upper 28 bits zero; back-to-back vectors one per cycle.

Source files
------------

// File: rtl/vec_serializer_if.sv
// Stream bundle between a vector source, the serializer and the cnt1 bit-count stage.
// The master modport is the serializer's view; the slave modport is the surrounding environment.
interface vec_serializer_if #(
    parameter int VECTOR_WIDTH = 920,
    parameter int BUS_WIDTH    = 128
);
    logic [VECTOR_WIDTH-1:0] up_Vector;
    logic                    up_Valid;
    logic                    up_Ready;
    logic [BUS_WIDTH-1:0]    dn_SubVector;
    logic                    dn_Valid;
    logic                    dn_First;
    logic                    dn_Last;
    logic                    dn_Ready;

    modport master (
        input  up_Vector, up_Valid, dn_Ready,
        output up_Ready, dn_SubVector, dn_Valid, dn_First, dn_Last
    );

    modport slave (
        output up_Vector, up_Valid, dn_Ready,
        input  up_Ready, dn_SubVector, dn_Valid, dn_First, dn_Last
    );
endinterface

// File: rtl/vec_serializer.sv
// Splits one VECTOR_WIDTH-bit fingerprint into SUB_VECTOR_NO BUS_WIDTH words, LSB word first,
// over a valid/ready stream; a new vector can load on the last word's handshake (no bubble).
module vec_serializer #(
    parameter int VECTOR_WIDTH = 920,
    parameter int BUS_WIDTH    = 128
) (
    input logic                clk,
    input logic                rst,
    vec_serializer_if.master   bus
);
    localparam int SUB_VECTOR_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int WORD_CNTR_WIDTH = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam int HOLD_WIDTH      = SUB_VECTOR_NO * BUS_WIDTH;
    localparam logic [WORD_CNTR_WIDTH-1:0] LAST_INDEX = WORD_CNTR_WIDTH'(SUB_VECTOR_NO - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                     state_q, state_d;
    logic [WORD_CNTR_WIDTH-1:0] index_q, index_d;
    logic [HOLD_WIDTH-1:0]      hold_q, hold_d;
    logic [HOLD_WIDTH-1:0]      load_vec;
    logic                       is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            hold_q  <= hold_d;
        end
    end

    // The holding register shifts down one word per handshake, so the current word is always at the bottom.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        hold_d   = hold_q;
        load_vec = '0;
        load_vec[VECTOR_WIDTH-1:0] = bus.up_Vector;
        is_last  = (state_q == SEND) && (index_q == LAST_INDEX);

        case (state_q)
            IDLE: begin
                if (bus.up_Valid) begin
                    hold_d  = load_vec;
                    index_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.dn_Ready) begin
                    if (!is_last) begin
                        index_d = index_q + 1'b1;
                        hold_d  = hold_q >> BUS_WIDTH;
                    end else if (bus.up_Valid) begin
                        hold_d  = load_vec;
                        index_d = '0;
                    end else begin
                        index_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    assign bus.up_Ready     = (state_q == IDLE) || (is_last && bus.dn_Ready);
    assign bus.dn_Valid     = (state_q == SEND);
    assign bus.dn_First     = (state_q == SEND) && (index_q == '0);
    assign bus.dn_Last      = is_last;
    assign bus.dn_SubVector = (state_q == SEND) ? hold_q[BUS_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_vec_serializer.sv
// Directed bench for vec_serializer: 920-bit/128-bit instance for the main scenarios and a
// 100-bit/128-bit instance for the single-word-per-vector case.
module tb_vec_serializer;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    vec_serializer_if #(.VECTOR_WIDTH(920), .BUS_WIDTH(128)) ifa ();
    vec_serializer_if #(.VECTOR_WIDTH(100), .BUS_WIDTH(128)) ifb ();

    vec_serializer #(.VECTOR_WIDTH(920), .BUS_WIDTH(128)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    vec_serializer #(.VECTOR_WIDTH(100), .BUS_WIDTH(128)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [919:0] vec, input logic ready);
        ifa.up_Valid  = valid;
        ifa.up_Vector = vec;
        ifa.dn_Ready  = ready;
    endtask

    // Word k of a test vector is 16 copies of (base+k); the top word keeps only 24 real bits.
    function automatic logic [919:0] make_vec(input logic [7:0] base);
        logic [1023:0] full;
        for (int k = 0; k < 8; k++) full[k*128 +: 128] = {16{base + 8'(k)}};
        return full[919:0];
    endfunction

    function automatic logic [127:0] exp_word(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(k);
        if (k < 7) return {16{b}};
        return {104'h0, b, b, b};
    endfunction

    initial begin
        logic [919:0] alt_vec;
        logic [919:0] vec_a;
        logic [919:0] vec_b;
        logic [99:0]  small_vec [3];
        int           exp_k;
        int           cyc;

        n_compared   = 0;
        n_mismatched = 0;
        for (int i = 0; i < 920; i++) alt_vec[i] = 1'(i % 2);
        vec_a = make_vec(8'h01);
        vec_b = make_vec(8'h10);
        small_vec[0] = 100'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        small_vec[1] = 100'h1_2345_6789_ABCD_EF01_2345_6789;
        small_vec[2] = 100'hA_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;

        // Reset held three cycles while a vector is offered; nothing may load.
        rst = 1'b1;
        apply_stimulus(1'b1, alt_vec, 1'b1);
        ifb.up_Valid  = 1'b1;
        ifb.up_Vector = small_vec[0];
        ifb.dn_Ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_dn_valid", 128'(ifa.dn_Valid), 128'h0);
        check_output("rst_b_dn_valid", 128'(ifb.dn_Valid), 128'h0);
        rst = 1'b0;
        apply_stimulus(1'b0, alt_vec, 1'b1);
        ifb.up_Valid = 1'b0;
        @(negedge clk);
        #1;
        check_output("idle_dn_valid", 128'(ifa.dn_Valid), 128'h0);
        check_output("idle_up_ready", 128'(ifa.up_Ready), 128'h1);
        check_output("idle_first", 128'(ifa.dn_First), 128'h0);
        check_output("idle_last", 128'(ifa.dn_Last), 128'h0);
        check_output("idle_subvec", ifa.dn_SubVector, 128'h0);

        // Single alternating-bit vector with the sink always ready.
        @(negedge clk);
        apply_stimulus(1'b1, alt_vec, 1'b1);
        #1;
        check_output("single_up_ready", 128'(ifa.up_Ready), 128'h1);
        @(negedge clk);
        apply_stimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            check_output("single_valid", 128'(ifa.dn_Valid), 128'h1);
            check_output("single_word", ifa.dn_SubVector,
                         (k < 7) ? {16{8'hAA}} : {104'h0, 24'hAAAAAA});
            check_output("single_first", 128'(ifa.dn_First), 128'(k == 0));
            check_output("single_last", 128'(ifa.dn_Last), 128'(k == 7));
            check_output("single_up_ready_busy", 128'(ifa.up_Ready), 128'(k == 7));
            @(negedge clk);
        end
        #1;
        check_output("single_done_valid", 128'(ifa.dn_Valid), 128'h0);

        // Backpressure: ready pattern 1,0,0 repeating; each word appears once and holds during stalls.
        @(negedge clk);
        apply_stimulus(1'b1, vec_a, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, vec_b, 1'b0);
        exp_k = 0;
        cyc   = 0;
        while (exp_k < 8 && cyc < 40) begin
            ifa.dn_Ready = (cyc % 3 == 0);
            #1;
            check_output("bp_valid", 128'(ifa.dn_Valid), 128'h1);
            check_output("bp_word", ifa.dn_SubVector, exp_word(8'h01, exp_k));
            check_output("bp_last", 128'(ifa.dn_Last), 128'(exp_k == 7));
            check_output("bp_up_ready", 128'(ifa.up_Ready), 128'(exp_k == 7 && ifa.dn_Ready));
            @(negedge clk);
            if (ifa.dn_Ready) exp_k++;
            cyc++;
        end
        check_output("bp_words_done", 128'(exp_k), 128'd8);
        ifa.dn_Ready = 1'b1;
        #1;
        check_output("bp_done_valid", 128'(ifa.dn_Valid), 128'h0);

        // Back-to-back vectors: the second loads on the first one's last-word handshake.
        @(negedge clk);
        apply_stimulus(1'b1, vec_a, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b1, vec_b, 1'b1);
        for (int c = 0; c < 16; c++) begin
            if (c == 8) ifa.up_Valid = 1'b0;
            #1;
            check_output("b2b_valid", 128'(ifa.dn_Valid), 128'h1);
            check_output("b2b_word", ifa.dn_SubVector,
                         (c < 8) ? exp_word(8'h01, c) : exp_word(8'h10, c - 8));
            check_output("b2b_first", 128'(ifa.dn_First), 128'(c % 8 == 0));
            check_output("b2b_up_ready", 128'(ifa.up_Ready), 128'(c % 8 == 7));
            @(negedge clk);
        end
        #1;
        check_output("b2b_done_valid", 128'(ifa.dn_Valid), 128'h0);

        // Reset after word 3 discards the rest; a fresh vector restarts at word 0.
        @(negedge clk);
        apply_stimulus(1'b1, vec_a, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output("mid_word", ifa.dn_SubVector, exp_word(8'h01, k));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("mid_rst_valid", 128'(ifa.dn_Valid), 128'h0);
        check_output("mid_rst_up_ready", 128'(ifa.up_Ready), 128'h1);
        check_output("mid_rst_subvec", ifa.dn_SubVector, 128'h0);
        @(negedge clk);
        apply_stimulus(1'b1, vec_b, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, '0, 1'b1);
        #1;
        check_output("restart_first", 128'(ifa.dn_First), 128'h1);
        check_output("restart_word0", ifa.dn_SubVector, exp_word(8'h10, 0));
        @(negedge clk);
        #1;
        check_output("restart_word1", ifa.dn_SubVector, exp_word(8'h10, 1));
        repeat (7) @(negedge clk);

        // Narrow instance: one padded word per vector, streamed one per cycle.
        #1;
        check_output("small_idle_valid", 128'(ifb.dn_Valid), 128'h0);
        @(negedge clk);
        ifb.up_Valid  = 1'b1;
        ifb.up_Vector = small_vec[0];
        ifb.dn_Ready  = 1'b1;
        @(negedge clk);
        ifb.up_Vector = small_vec[1];
        #1;
        check_output("small_word0", ifb.dn_SubVector, 128'h0000_000F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        check_output("small_first0", 128'(ifb.dn_First), 128'h1);
        check_output("small_last0", 128'(ifb.dn_Last), 128'h1);
        check_output("small_up_ready0", 128'(ifb.up_Ready), 128'h1);
        @(negedge clk);
        ifb.up_Vector = small_vec[2];
        #1;
        check_output("small_word1", ifb.dn_SubVector, 128'h0000_0001_2345_6789_ABCD_EF01_2345_6789);
        check_output("small_valid1", 128'(ifb.dn_Valid), 128'h1);
        @(negedge clk);
        ifb.up_Valid = 1'b0;
        #1;
        check_output("small_word2", ifb.dn_SubVector, 128'h0000_000A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A);
        check_output("small_first2", 128'(ifb.dn_First), 128'h1);
        check_output("small_last2", 128'(ifb.dn_Last), 128'h1);
        @(negedge clk);
        #1;
        check_output("small_done_valid", 128'(ifb.dn_Valid), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
